// File: rtl/fetch_unit_pkg.sv
// Shared front-end definitions: bus widths, exception flag positions and fetch-stage types.
package fetch_unit_pkg;

  localparam int BR_BUS_WD       = 33;
  localparam int EXC_NUM         = 6;
  localparam int EXC_FLG_ADEF    = 1;
  localparam int FS_TO_DS_BUS_WD = EXC_NUM + 64;

  localparam int          IBUF_DEPTH_DEFAULT = 4;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h1c00_0000;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_ADEF,
    FS_HALT
  } fetch_state_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic [EXC_NUM-1:0] exc_flgs;
    logic [31:0]        inst;
    logic [31:0]        pc;
  } fs_entry_t;

  function automatic logic [EXC_NUM-1:0] exc_flag(input int idx);
    return EXC_NUM'(1) << idx;
  endfunction

endpackage

// File: rtl/fetch_ibuf.sv
// Instruction buffer: power-of-two synchronous FIFO with a synchronous clear.
module fetch_ibuf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (32'(count) == DEPTH);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + NW'(do_push) - NW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pipelined SRAM requests, redirect with response discard, buffered hand-off to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          IBUF_DEPTH      = IBUF_DEPTH_DEFAULT,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  input  logic                       flush,
  input  logic [31:0]                flush_target,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int NW = $clog2(IBUF_DEPTH) + 1;

  fetch_state_e   state, state_nxt;
  br_bus_t        br;
  logic [31:0]    fetch_pc, resp_pc, req_addr, redirect_pc;
  logic           req_hold, req_stale, redirect, can_issue, handshake, req_wait;
  logic           resp, resp_keep, adef_push;
  logic [CW-1:0]  outstanding, discard_cnt, outstanding_nxt, discard_nxt;
  logic           ib_push, ib_pop, ib_full, ib_empty;
  logic [NW-1:0]  ib_count;
  fs_entry_t      push_entry, head_entry;

  assign br          = br_bus;
  assign redirect    = flush | br.taken;
  assign redirect_pc = flush ? flush_target : br.target;

  // Each accepted request reserves a buffer slot, so the buffer can never overflow.
  assign can_issue = (state == FS_RUN) && (32'(outstanding) < MAX_OUTSTANDING) &&
                     (32'(ib_count) + 32'(outstanding) < IBUF_DEPTH);

  assign inst_sram_req  = resetn & (req_hold | can_issue);
  assign inst_sram_addr = req_hold ? req_addr : fetch_pc;
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'd2;

  assign handshake = inst_sram_req & inst_sram_addr_ok;
  assign req_wait  = inst_sram_req & ~inst_sram_addr_ok;
  assign resp      = inst_sram_data_ok & (outstanding != '0);
  assign resp_keep = resp & (discard_cnt == '0) & ~redirect;
  assign adef_push = (state == FS_ADEF) && (outstanding == '0) && !req_hold && !redirect && !ib_full;

  assign outstanding_nxt = outstanding + CW'(handshake) - CW'(resp);

  // On redirect everything still owed by the SRAM belongs to the old stream, including a request not yet accepted.
  always_comb begin
    discard_nxt = discard_cnt;
    if (redirect) begin
      discard_nxt = outstanding + CW'(inst_sram_req) - CW'(resp);
    end else if (resp && discard_cnt != '0) begin
      discard_nxt = discard_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = (redirect_pc[1:0] != 2'b00) ? FS_ADEF : FS_RUN;
    end else if (adef_push) begin
      state_nxt = FS_HALT;
    end
  end

  always_comb begin
    push_entry = '{exc_flgs: '0, inst: inst_sram_rdata, pc: resp_pc};
    if (adef_push) begin
      push_entry = '{exc_flgs: exc_flag(EXC_FLG_ADEF), inst: 32'h0, pc: fetch_pc};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= FS_RUN;
    else         state <= state_nxt;
  end

  // A request that was up when a redirect hit stays stale until accepted and must not advance the new stream.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      req_addr    <= RESET_PC;
      req_hold    <= 1'b0;
      req_stale   <= 1'b0;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      discard_cnt <= discard_nxt;
      req_hold    <= req_wait;
      req_stale   <= req_wait & (req_stale | redirect);
      if (req_wait) req_addr <= inst_sram_addr;
      if (redirect)                     fetch_pc <= redirect_pc;
      else if (handshake && !req_stale) fetch_pc <= fetch_pc + 32'd4;
      if (redirect)       resp_pc <= redirect_pc;
      else if (resp_keep) resp_pc <= resp_pc + 32'd4;
    end
  end

  assign ib_push = resp_keep | adef_push;
  assign ib_pop  = fs_to_ds_valid & ds_allowin;

  fetch_ibuf #(
    .WIDTH (FS_TO_DS_BUS_WD),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (redirect),
    .push      (ib_push),
    .push_data (push_entry),
    .pop       (ib_pop),
    .head      (head_entry),
    .full      (ib_full),
    .empty     (ib_empty),
    .count     (ib_count)
  );

  assign fs_to_ds_valid = ~ib_empty;
  assign fs_to_ds_bus   = head_entry;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter IBUF_DEPTH, default 4, instruction-buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, accepted-but-unanswered SRAM requests (1..IBUF_DEPTH).
REQ-003 SHALL have parameter RESET_PC, default 32'h1c000000, first fetch address.
REQ-004 SHALL have ports: clk in 1, sole clock; resetn in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: ds_allowin in 1, decode accepts; br_bus in BR_BUS_WD, {br_taken, br_target[31:0]}.
REQ-006 SHALL have ports: flush in 1, exception/ertn redirect; flush_target in 32, redirect PC.
REQ-007 SHALL have ports: fs_to_ds_valid out 1; fs_to_ds_bus out FS_TO_DS_BUS_WD, {exc_flgs, inst, pc}.
REQ-008 SHALL have ports: inst_sram_req out 1; inst_sram_wr out 1 (const 0); inst_sram_size out 2 (const 2); inst_sram_addr out 32.
REQ-009 SHALL have ports: inst_sram_addr_ok in 1; inst_sram_data_ok in 1; inst_sram_rdata in 32.

Function
REQ-010 SHALL issue a request when not halted, outstanding < MAX_OUTSTANDING and free buffer slots > outstanding count.
REQ-011 SHALL hold inst_sram_req and inst_sram_addr stable from assertion until the cycle addr_ok=1.
REQ-012 SHALL advance fetch PC by 4 on each req&addr_ok handshake; back-to-back handshakes permitted.
REQ-013 SHALL treat responses as in-order; each data_ok decrements outstanding and pushes {pc, rdata, adef=0}.
REQ-014 SHALL redirect on flush (priority) or br_taken: fetch PC := target; buffer emptied that cycle; all outstanding responses, plus a req pending without addr_ok, counted into discard_cnt.
REQ-015 SHALL drop data_ok responses while discard_cnt>0, decrementing discard_cnt, with no push.
REQ-016 SHALL not issue new-stream requests until the pending req handshakes; discarded requests never reach the buffer.
REQ-017 SHALL, for target[1:0]!=0, issue no request, push one entry {pc=target, inst=0, ADEF=1, other flags 0} once older responses drain, then halt until next redirect.
REQ-018 SHALL drive fs_to_ds_valid = buffer non-empty, bus = head entry; pop when valid & ds_allowin.
REQ-019 SHALL allow push and pop in the same cycle, including with buffer full.
REQ-020 SHALL, when redirect and data_ok coincide, discard that response (counted in discard_cnt before decrement).
REQ-021 SHALL keep outstanding and discard_cnt within log2(MAX_OUTSTANDING)+1 bits, never underflowing.

Reset
REQ-022 SHALL on resetn=0 asynchronously set fetch PC=RESET_PC, outstanding=0, discard_cnt=0, buffer empty, halt=0.
REQ-023 SHALL hold inst_sram_req=0, fs_to_ds_valid=0 during reset; first request in first cycle after release with addr=RESET_PC.
REQ-024 SHALL drop any data_ok arriving during reset; reset mid-transaction needs no SRAM-side cleanup.

Structure
REQ-025 SHALL take BR_BUS_WD, FS_TO_DS_BUS_WD, EXC_NUM and EXC_FLG_* from the shared mycpu.h header; IBUF_DEPTH default also defined there.
REQ-026 SHALL instantiate one sub-module fetch_ibuf: parametrised synchronous FIFO with clear, full, empty, count outputs.

Verification
REQ-027 SHALL cover: reset release, addr_ok=1 and data_ok next cycle always, ds_allowin=1 -> pc 0x1c000000, 0x1c000004, 0x1c000008 delivered in order, one per cycle.
REQ-028 SHALL cover: ds_allowin=0 for 10 cycles -> IBUF_DEPTH entries buffered, req low, no overflow; release -> FIFO order preserved.
REQ-029 SHALL cover: br_taken to 0x1c000100 with 2 outstanding -> both responses dropped, next delivered pc 0x1c000100.
REQ-030 SHALL cover: flush and br_taken same cycle, flush_target 0x1c008000 -> flush wins, next pc 0x1c008000.
REQ-031 SHALL cover: br_target 0x1c000102 -> no request; one entry pc 0x1c000102 with ADEF=1, inst 0; halted until flush.
REQ-032 SHALL cover: addr_ok low 5 cycles with redirect in cycle 2 -> addr held stable, accepted request's response discarded.
